// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that time-shares one UART transmitter among NUM_REQ byte sources.
// Optional tx_done watchdog is compiled in with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic                 busy,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [1:0]           dbg_state
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Handshake: ack[i] pulses for one cycle when byte i is captured; the source must
  // then drop req[i] or present its next byte on the following cycle.
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       rr_ptr, rr_ptr_nxt, cur, cur_nxt, win, idx;
  logic [7:0]          tx_data_nxt;
  logic                trmt_nxt, tx_done_q, done_rise;
  logic [NUM_REQ-1:0]  ack_nxt, done_nxt;
  logic [15:0]         gap_cnt, gap_cnt_nxt;
`ifdef UART_TX_ARB_TIMEOUT_EN
  // err lands TIMEOUT_CYCLES clocks after the trmt pulse.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 2);
  logic [15:0] to_cnt, to_cnt_nxt;
  logic        err_nxt;
`endif

  assign done_rise = tx_done & ~tx_done_q;
  assign dbg_state = state;

  // Search starts just past the last winner, so that winner has lowest priority.
  always_comb begin
    win = rr_ptr;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    cur_nxt     = cur;
    tx_data_nxt = tx_data;
    trmt_nxt    = 1'b0;
    ack_nxt     = '0;
    done_nxt    = '0;
    gap_cnt_nxt = gap_cnt;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_nxt  = to_cnt;
    err_nxt     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt   = LAUNCH;
          cur_nxt     = win;
          rr_ptr_nxt  = win;
          tx_data_nxt = req_data[8*win +: 8];
          trmt_nxt    = 1'b1;
          ack_nxt     = NUM_REQ'(1) << win;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
        to_cnt_nxt = '0;
`endif
      end
      WAIT: begin
        if (done_rise) begin
          done_nxt = NUM_REQ'(1) << cur;
          if (GAP_CYCLES > 0) begin
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 16'd1;
        end
`endif
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else gap_cnt_nxt = gap_cnt + 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NUM_REQ - 1);
      cur       <= '0;
      tx_data   <= 8'h00;
      trmt      <= 1'b0;
      ack       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      gap_cnt   <= '0;
      tx_done_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      cur       <= cur_nxt;
      tx_data   <= tx_data_nxt;
      trmt      <= trmt_nxt;
      ack       <= ack_nxt;
      done      <= done_nxt;
      busy      <= (state_nxt != IDLE);
      gap_cnt   <= gap_cnt_nxt;
      tx_done_q <= tx_done;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nxt;
      err    <= err_nxt;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
